chr_huffman_lut: RTL and testbench

- Registered chrominance Huffman code lookup for the JPEG baseline encoder.
- Maps a DC size category, or an AC (run, size) pair, to its code word and code length.
- Uses the standard chrominance tables: ITU-T T.81 Annex K, Table K.4 (DC) and Table K.6 (AC).
- Sits between the size-category stage and the extra-bit append/left-align stage of the chroma entropy encoder.

---
 rtl/chr_huffman_lut.sv | 241 ++++++++++++++++++++++++
 tb/tb_chr_huffman_lut.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/chr_huffman_lut.sv
// Chroma JPEG Huffman code lookup (DC K.4 / AC K.6), one registered stage.
// Code words are right-aligned; length 0 flags an undefined symbol.
module chr_huffman_lut #(
  parameter logic DC_COEFF = 1'b0,
  parameter logic AC_COEFF = 1'b1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        in_valid,
  input  logic        in_type,
  input  logic [3:0]  extra_bits,
  input  logic [3:0]  run_length,
  output logic        out_valid,
  output logic [15:0] code,
  output logic [4:0]  length
);

  logic        valid_q;
  logic [15:0] code_q;
  logic [4:0]  length_q;
  logic [20:0] ent_d;
  logic [20:0] dc_e;
  logic [20:0] ac_e;

  always_comb begin
    dc_e = '0;
    case (extra_bits)
      4'd0:  dc_e = {5'd2,  16'h0000};
      4'd1:  dc_e = {5'd2,  16'h0001};
      4'd2:  dc_e = {5'd2,  16'h0002};
      4'd3:  dc_e = {5'd3,  16'h0006};
      4'd4:  dc_e = {5'd4,  16'h000E};
      4'd5:  dc_e = {5'd5,  16'h001E};
      4'd6:  dc_e = {5'd6,  16'h003E};
      4'd7:  dc_e = {5'd7,  16'h007E};
      4'd8:  dc_e = {5'd8,  16'h00FE};
      4'd9:  dc_e = {5'd9,  16'h01FE};
      4'd10: dc_e = {5'd10, 16'h03FE};
      4'd11: dc_e = {5'd11, 16'h07FE};
      default: dc_e = '0;
    endcase
  end

  // Key is {RRRR, SSSS}; entries packed as {length, code}
  always_comb begin
    ac_e = '0;
    case ({run_length, extra_bits})
      8'h00: ac_e = {5'd2,  16'h0000};
      8'h01: ac_e = {5'd2,  16'h0001};
      8'h02: ac_e = {5'd3,  16'h0004};
      8'h03: ac_e = {5'd4,  16'h000A};
      8'h04: ac_e = {5'd5,  16'h0018};
      8'h05: ac_e = {5'd5,  16'h0019};
      8'h06: ac_e = {5'd6,  16'h0038};
      8'h07: ac_e = {5'd7,  16'h0078};
      8'h08: ac_e = {5'd9,  16'h01F4};
      8'h09: ac_e = {5'd10, 16'h03F6};
      8'h0A: ac_e = {5'd12, 16'h0FF4};
      8'h11: ac_e = {5'd4,  16'h000B};
      8'h12: ac_e = {5'd6,  16'h0039};
      8'h13: ac_e = {5'd8,  16'h00F6};
      8'h14: ac_e = {5'd9,  16'h01F5};
      8'h15: ac_e = {5'd11, 16'h07F6};
      8'h16: ac_e = {5'd12, 16'h0FF5};
      8'h17: ac_e = {5'd16, 16'hFF88};
      8'h18: ac_e = {5'd16, 16'hFF89};
      8'h19: ac_e = {5'd16, 16'hFF8A};
      8'h1A: ac_e = {5'd16, 16'hFF8B};
      8'h21: ac_e = {5'd5,  16'h001A};
      8'h22: ac_e = {5'd8,  16'h00F7};
      8'h23: ac_e = {5'd10, 16'h03F7};
      8'h24: ac_e = {5'd12, 16'h0FF6};
      8'h25: ac_e = {5'd15, 16'h7FC2};
      8'h26: ac_e = {5'd16, 16'hFF8C};
      8'h27: ac_e = {5'd16, 16'hFF8D};
      8'h28: ac_e = {5'd16, 16'hFF8E};
      8'h29: ac_e = {5'd16, 16'hFF8F};
      8'h2A: ac_e = {5'd16, 16'hFF90};
      8'h31: ac_e = {5'd5,  16'h001B};
      8'h32: ac_e = {5'd8,  16'h00F8};
      8'h33: ac_e = {5'd10, 16'h03F8};
      8'h34: ac_e = {5'd12, 16'h0FF7};
      8'h35: ac_e = {5'd16, 16'hFF91};
      8'h36: ac_e = {5'd16, 16'hFF92};
      8'h37: ac_e = {5'd16, 16'hFF93};
      8'h38: ac_e = {5'd16, 16'hFF94};
      8'h39: ac_e = {5'd16, 16'hFF95};
      8'h3A: ac_e = {5'd16, 16'hFF96};
      8'h41: ac_e = {5'd6,  16'h003A};
      8'h42: ac_e = {5'd9,  16'h01F6};
      8'h43: ac_e = {5'd16, 16'hFF97};
      8'h44: ac_e = {5'd16, 16'hFF98};
      8'h45: ac_e = {5'd16, 16'hFF99};
      8'h46: ac_e = {5'd16, 16'hFF9A};
      8'h47: ac_e = {5'd16, 16'hFF9B};
      8'h48: ac_e = {5'd16, 16'hFF9C};
      8'h49: ac_e = {5'd16, 16'hFF9D};
      8'h4A: ac_e = {5'd16, 16'hFF9E};
      8'h51: ac_e = {5'd6,  16'h003B};
      8'h52: ac_e = {5'd10, 16'h03F9};
      8'h53: ac_e = {5'd16, 16'hFF9F};
      8'h54: ac_e = {5'd16, 16'hFFA0};
      8'h55: ac_e = {5'd16, 16'hFFA1};
      8'h56: ac_e = {5'd16, 16'hFFA2};
      8'h57: ac_e = {5'd16, 16'hFFA3};
      8'h58: ac_e = {5'd16, 16'hFFA4};
      8'h59: ac_e = {5'd16, 16'hFFA5};
      8'h5A: ac_e = {5'd16, 16'hFFA6};
      8'h61: ac_e = {5'd7,  16'h0079};
      8'h62: ac_e = {5'd11, 16'h07F7};
      8'h63: ac_e = {5'd16, 16'hFFA7};
      8'h64: ac_e = {5'd16, 16'hFFA8};
      8'h65: ac_e = {5'd16, 16'hFFA9};
      8'h66: ac_e = {5'd16, 16'hFFAA};
      8'h67: ac_e = {5'd16, 16'hFFAB};
      8'h68: ac_e = {5'd16, 16'hFFAC};
      8'h69: ac_e = {5'd16, 16'hFFAD};
      8'h6A: ac_e = {5'd16, 16'hFFAE};
      8'h71: ac_e = {5'd7,  16'h007A};
      8'h72: ac_e = {5'd11, 16'h07F8};
      8'h73: ac_e = {5'd16, 16'hFFAF};
      8'h74: ac_e = {5'd16, 16'hFFB0};
      8'h75: ac_e = {5'd16, 16'hFFB1};
      8'h76: ac_e = {5'd16, 16'hFFB2};
      8'h77: ac_e = {5'd16, 16'hFFB3};
      8'h78: ac_e = {5'd16, 16'hFFB4};
      8'h79: ac_e = {5'd16, 16'hFFB5};
      8'h7A: ac_e = {5'd16, 16'hFFB6};
      8'h81: ac_e = {5'd8,  16'h00F9};
      8'h82: ac_e = {5'd16, 16'hFFB7};
      8'h83: ac_e = {5'd16, 16'hFFB8};
      8'h84: ac_e = {5'd16, 16'hFFB9};
      8'h85: ac_e = {5'd16, 16'hFFBA};
      8'h86: ac_e = {5'd16, 16'hFFBB};
      8'h87: ac_e = {5'd16, 16'hFFBC};
      8'h88: ac_e = {5'd16, 16'hFFBD};
      8'h89: ac_e = {5'd16, 16'hFFBE};
      8'h8A: ac_e = {5'd16, 16'hFFBF};
      8'h91: ac_e = {5'd9,  16'h01F7};
      8'h92: ac_e = {5'd16, 16'hFFC0};
      8'h93: ac_e = {5'd16, 16'hFFC1};
      8'h94: ac_e = {5'd16, 16'hFFC2};
      8'h95: ac_e = {5'd16, 16'hFFC3};
      8'h96: ac_e = {5'd16, 16'hFFC4};
      8'h97: ac_e = {5'd16, 16'hFFC5};
      8'h98: ac_e = {5'd16, 16'hFFC6};
      8'h99: ac_e = {5'd16, 16'hFFC7};
      8'h9A: ac_e = {5'd16, 16'hFFC8};
      8'hA1: ac_e = {5'd9,  16'h01F8};
      8'hA2: ac_e = {5'd16, 16'hFFC9};
      8'hA3: ac_e = {5'd16, 16'hFFCA};
      8'hA4: ac_e = {5'd16, 16'hFFCB};
      8'hA5: ac_e = {5'd16, 16'hFFCC};
      8'hA6: ac_e = {5'd16, 16'hFFCD};
      8'hA7: ac_e = {5'd16, 16'hFFCE};
      8'hA8: ac_e = {5'd16, 16'hFFCF};
      8'hA9: ac_e = {5'd16, 16'hFFD0};
      8'hAA: ac_e = {5'd16, 16'hFFD1};
      8'hB1: ac_e = {5'd9,  16'h01F9};
      8'hB2: ac_e = {5'd16, 16'hFFD2};
      8'hB3: ac_e = {5'd16, 16'hFFD3};
      8'hB4: ac_e = {5'd16, 16'hFFD4};
      8'hB5: ac_e = {5'd16, 16'hFFD5};
      8'hB6: ac_e = {5'd16, 16'hFFD6};
      8'hB7: ac_e = {5'd16, 16'hFFD7};
      8'hB8: ac_e = {5'd16, 16'hFFD8};
      8'hB9: ac_e = {5'd16, 16'hFFD9};
      8'hBA: ac_e = {5'd16, 16'hFFDA};
      8'hC1: ac_e = {5'd9,  16'h01FA};
      8'hC2: ac_e = {5'd16, 16'hFFDB};
      8'hC3: ac_e = {5'd16, 16'hFFDC};
      8'hC4: ac_e = {5'd16, 16'hFFDD};
      8'hC5: ac_e = {5'd16, 16'hFFDE};
      8'hC6: ac_e = {5'd16, 16'hFFDF};
      8'hC7: ac_e = {5'd16, 16'hFFE0};
      8'hC8: ac_e = {5'd16, 16'hFFE1};
      8'hC9: ac_e = {5'd16, 16'hFFE2};
      8'hCA: ac_e = {5'd16, 16'hFFE3};
      8'hD1: ac_e = {5'd11, 16'h07F9};
      8'hD2: ac_e = {5'd16, 16'hFFE4};
      8'hD3: ac_e = {5'd16, 16'hFFE5};
      8'hD4: ac_e = {5'd16, 16'hFFE6};
      8'hD5: ac_e = {5'd16, 16'hFFE7};
      8'hD6: ac_e = {5'd16, 16'hFFE8};
      8'hD7: ac_e = {5'd16, 16'hFFE9};
      8'hD8: ac_e = {5'd16, 16'hFFEA};
      8'hD9: ac_e = {5'd16, 16'hFFEB};
      8'hDA: ac_e = {5'd16, 16'hFFEC};
      8'hE1: ac_e = {5'd14, 16'h3FE0};
      8'hE2: ac_e = {5'd16, 16'hFFED};
      8'hE3: ac_e = {5'd16, 16'hFFEE};
      8'hE4: ac_e = {5'd16, 16'hFFEF};
      8'hE5: ac_e = {5'd16, 16'hFFF0};
      8'hE6: ac_e = {5'd16, 16'hFFF1};
      8'hE7: ac_e = {5'd16, 16'hFFF2};
      8'hE8: ac_e = {5'd16, 16'hFFF3};
      8'hE9: ac_e = {5'd16, 16'hFFF4};
      8'hEA: ac_e = {5'd16, 16'hFFF5};
      8'hF0: ac_e = {5'd10, 16'h03FA};
      8'hF1: ac_e = {5'd15, 16'h7FC3};
      8'hF2: ac_e = {5'd16, 16'hFFF6};
      8'hF3: ac_e = {5'd16, 16'hFFF7};
      8'hF4: ac_e = {5'd16, 16'hFFF8};
      8'hF5: ac_e = {5'd16, 16'hFFF9};
      8'hF6: ac_e = {5'd16, 16'hFFFA};
      8'hF7: ac_e = {5'd16, 16'hFFFB};
      8'hF8: ac_e = {5'd16, 16'hFFFC};
      8'hF9: ac_e = {5'd16, 16'hFFFD};
      8'hFA: ac_e = {5'd16, 16'hFFFE};
      default: ac_e = '0;
    endcase
  end

  always_comb begin
    ent_d = '0;
    if (in_type == AC_COEFF) begin
      ent_d = ac_e;
    end else if (in_type == DC_COEFF) begin
      ent_d = dc_e;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      valid_q  <= 1'b0;
      code_q   <= '0;
      length_q <= '0;
    end else begin
      valid_q <= in_valid;
      if (in_valid) begin
        length_q <= ent_d[20:16];
        code_q   <= ent_d[15:0];
      end
    end
  end

  assign out_valid = valid_q;
  assign code      = code_q;
  assign length    = length_q;

endmodule

// File: tb/tb_chr_huffman_lut.sv
// Directed bench for chr_huffman_lut; the AC sweep golden table is
// rebuilt canonically from the K.6 BITS/HUFFVAL lists.
module tb_chr_huffman_lut;

  logic        clk;
  logic        rstn;
  logic        in_valid;
  logic        in_type;
  logic [3:0]  extra_bits;
  logic [3:0]  run_length;
  logic        out_valid;
  logic [15:0] code;
  logic [4:0]  length;

  int n_pass;
  int n_chk;

  int bits_k6 [16] = '{0, 2, 1, 2, 4, 4, 3, 4, 7, 5, 4, 4, 0, 1, 2, 119};
  int vals_k6 [162] = '{
    8'h00, 8'h01, 8'h02, 8'h03, 8'h11, 8'h04, 8'h05, 8'h21,
    8'h31, 8'h06, 8'h12, 8'h41, 8'h51, 8'h07, 8'h61, 8'h71,
    8'h13, 8'h22, 8'h32, 8'h81, 8'h08, 8'h14, 8'h42, 8'h91,
    8'hA1, 8'hB1, 8'hC1, 8'h09, 8'h23, 8'h33, 8'h52, 8'hF0,
    8'h15, 8'h62, 8'h72, 8'hD1, 8'h0A, 8'h16, 8'h24, 8'h34,
    8'hE1, 8'h25, 8'hF1, 8'h17, 8'h18, 8'h19, 8'h1A, 8'h26,
    8'h27, 8'h28, 8'h29, 8'h2A, 8'h35, 8'h36, 8'h37, 8'h38,
    8'h39, 8'h3A, 8'h43, 8'h44, 8'h45, 8'h46, 8'h47, 8'h48,
    8'h49, 8'h4A, 8'h53, 8'h54, 8'h55, 8'h56, 8'h57, 8'h58,
    8'h59, 8'h5A, 8'h63, 8'h64, 8'h65, 8'h66, 8'h67, 8'h68,
    8'h69, 8'h6A, 8'h73, 8'h74, 8'h75, 8'h76, 8'h77, 8'h78,
    8'h79, 8'h7A, 8'h82, 8'h83, 8'h84, 8'h85, 8'h86, 8'h87,
    8'h88, 8'h89, 8'h8A, 8'h92, 8'h93, 8'h94, 8'h95, 8'h96,
    8'h97, 8'h98, 8'h99, 8'h9A, 8'hA2, 8'hA3, 8'hA4, 8'hA5,
    8'hA6, 8'hA7, 8'hA8, 8'hA9, 8'hAA, 8'hB2, 8'hB3, 8'hB4,
    8'hB5, 8'hB6, 8'hB7, 8'hB8, 8'hB9, 8'hBA, 8'hC2, 8'hC3,
    8'hC4, 8'hC5, 8'hC6, 8'hC7, 8'hC8, 8'hC9, 8'hCA, 8'hD2,
    8'hD3, 8'hD4, 8'hD5, 8'hD6, 8'hD7, 8'hD8, 8'hD9, 8'hDA,
    8'hE2, 8'hE3, 8'hE4, 8'hE5, 8'hE6, 8'hE7, 8'hE8, 8'hE9,
    8'hEA, 8'hF2, 8'hF3, 8'hF4, 8'hF5, 8'hF6, 8'hF7, 8'hF8,
    8'hF9, 8'hFA
  };

  logic [15:0] g_code [256];
  logic [4:0]  g_len  [256];

  chr_huffman_lut dut (
    .clk        (clk),
    .rstn       (rstn),
    .in_valid   (in_valid),
    .in_type    (in_type),
    .extra_bits (extra_bits),
    .run_length (run_length),
    .out_valid  (out_valid),
    .code       (code),
    .length     (length)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply one cycle of inputs, then settle just past the capturing edge
  task automatic step(input logic v, input logic t,
                      input logic [3:0] r, input logic [3:0] s);
    @(negedge clk);
    in_valid   = v;
    in_type    = t;
    run_length = r;
    extra_bits = s;
    @(posedge clk);
    #1;
  endtask

  task automatic build_golden;
    int c;
    int k;
    c = 0;
    k = 0;
    for (int i = 0; i < 256; i++) begin
      g_code[i] = '0;
      g_len[i]  = '0;
    end
    for (int l = 1; l <= 16; l++) begin
      for (int n = 0; n < bits_k6[l-1]; n++) begin
        g_code[vals_k6[k]] = c[15:0];
        g_len[vals_k6[k]]  = l[4:0];
        c++;
        k++;
      end
      c = c << 1;
    end
  endtask

  task automatic test_reset;
    rstn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 4'd0, 4'd1);
      n_chk++;
      if ({out_valid, code, length} !== 22'd0)
        $display("FAIL reset[%0d]: got v=%0b c=%h l=%0d want 0/0000/0",
                 i, out_valid, code, length);
      else n_pass++;
    end
    rstn = 1'b1;
  endtask

  task automatic test_dc_sweep;
    logic [15:0] ec [13];
    logic [4:0]  el [13];
    ec = '{16'h0000, 16'h0001, 16'h0002, 16'h0006, 16'h000E, 16'h001E,
           16'h003E, 16'h007E, 16'h00FE, 16'h01FE, 16'h03FE, 16'h07FE,
           16'h0000};
    el = '{5'd2, 5'd2, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9,
           5'd10, 5'd11, 5'd0};
    for (int s = 0; s < 13; s++) begin
      step(1'b1, 1'b0, 4'd7, s[3:0]);
      n_chk++;
      if (out_valid !== 1'b1 || code !== ec[s] || length !== el[s])
        $display("FAIL dc[%0d]: got v=%0b c=%h l=%0d want 1/%h/%0d",
                 s, out_valid, code, length, ec[s], el[s]);
      else n_pass++;
    end
  endtask

  task automatic test_ac_spot;
    logic [7:0]  key [7];
    logic [15:0] ec  [7];
    logic [4:0]  el  [7];
    key = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h11, 8'hF0, 8'hFA};
    ec  = '{16'h0000, 16'h0001, 16'h0004, 16'h000A, 16'h000B,
            16'h03FA, 16'hFFFE};
    el  = '{5'd2, 5'd2, 5'd3, 5'd4, 5'd4, 5'd10, 5'd16};
    for (int i = 0; i < 7; i++) begin
      step(1'b1, 1'b1, key[i][7:4], key[i][3:0]);
      n_chk++;
      if (out_valid !== 1'b1 || code !== ec[i] || length !== el[i])
        $display("FAIL ac_spot[%h]: got v=%0b c=%h l=%0d want 1/%h/%0d",
                 key[i], out_valid, code, length, ec[i], el[i]);
      else n_pass++;
    end
  endtask

  task automatic test_ac_invalid;
    step(1'b1, 1'b1, 4'd5, 4'd0);
    n_chk++;
    if ({out_valid, code, length} !== {1'b1, 16'h0, 5'd0})
      $display("FAIL ac_inv_5_0: got v=%0b c=%h l=%0d want 1/0000/0",
               out_valid, code, length);
    else n_pass++;
    step(1'b1, 1'b1, 4'd0, 4'd11);
    n_chk++;
    if ({out_valid, code, length} !== {1'b1, 16'h0, 5'd0})
      $display("FAIL ac_inv_0_B: got v=%0b c=%h l=%0d want 1/0000/0",
               out_valid, code, length);
    else n_pass++;
  endtask

  task automatic test_hold;
    logic ev [4];
    ev = '{1'b1, 1'b0, 1'b0, 1'b0};
    step(1'b1, 1'b1, 4'd0, 4'd1);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) step(1'b0, i[0], 4'hF, 4'hA);
      n_chk++;
      if (out_valid !== ev[i] || code !== 16'h0001 || length !== 5'd2)
        $display("FAIL hold[%0d]: got v=%0b c=%h l=%0d want %0b/0001/2",
                 i, out_valid, code, length, ev[i]);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back;
    step(1'b1, 1'b0, 4'd0, 4'd2);
    n_chk++;
    if (out_valid !== 1'b1 || code !== 16'h0002 || length !== 5'd2)
      $display("FAIL b2b_dc: got v=%0b c=%h l=%0d want 1/0002/2",
               out_valid, code, length);
    else n_pass++;
    step(1'b1, 1'b1, 4'd0, 4'd2);
    n_chk++;
    if (out_valid !== 1'b1 || code !== 16'h0004 || length !== 5'd3)
      $display("FAIL b2b_ac: got v=%0b c=%h l=%0d want 1/0004/3",
               out_valid, code, length);
    else n_pass++;
    step(1'b1, 1'b0, 4'd0, 4'd11);
    n_chk++;
    if (out_valid !== 1'b1 || code !== 16'h07FE || length !== 5'd11)
      $display("FAIL b2b_dc11: got v=%0b c=%h l=%0d want 1/07FE/11",
               out_valid, code, length);
    else n_pass++;
  endtask

  task automatic test_mid_reset;
    step(1'b1, 1'b1, 4'hF, 4'hA);
    n_chk++;
    if (out_valid !== 1'b1 || code !== 16'hFFFE || length !== 5'd16)
      $display("FAIL midrst_pre: got v=%0b c=%h l=%0d want 1/FFFE/16",
               out_valid, code, length);
    else n_pass++;
    @(negedge clk);
    rstn = 1'b0;
    in_valid = 1'b1;
    run_length = 4'hF;
    extra_bits = 4'h0;
    @(posedge clk);
    #1;
    n_chk++;
    if ({out_valid, code, length} !== 22'd0)
      $display("FAIL midrst: got v=%0b c=%h l=%0d want 0/0000/0",
               out_valid, code, length);
    else n_pass++;
    rstn = 1'b1;
  endtask

  task automatic test_ac_sweep;
    logic [7:0] k;
    for (int i = 0; i < 256; i++) begin
      k = i[7:0];
      step(1'b1, 1'b1, k[7:4], k[3:0]);
      n_chk++;
      if (out_valid !== 1'b1 || code !== g_code[i] || length !== g_len[i])
        $display("FAIL ac_sweep[%h]: got v=%0b c=%h l=%0d want 1/%h/%0d",
                 k, out_valid, code, length, g_code[i], g_len[i]);
      else n_pass++;
    end
  endtask

  initial begin
    n_pass = 0;
    n_chk = 0;
    rstn = 1'b0;
    in_valid = 1'b0;
    in_type = 1'b0;
    run_length = 4'd0;
    extra_bits = 4'd0;
    build_golden();
    test_reset();
    test_dc_sweep();
    test_ac_spot();
    test_ac_invalid();
    test_hold();
    test_back_to_back();
    test_mid_reset();
    test_ac_sweep();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
